// File: rtl/axi_lite_rd_arbiter.sv
// axi_lite_rd_arbiter: shares the AR/R channels of one AXI-lite slave among
// N_MST read masters with a single outstanding transaction.
// Build option: define ARB_FIXED_PRIO_EN for fixed (lowest-index) priority;
// the default build uses round-robin arbitration.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module axi_lite_rd_arbiter #(
   parameter int unsigned N_MST = 2,
   parameter int unsigned AW    = `CPU_WIDTH,
   parameter int unsigned DW    = `CPU_WIDTH
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [N_MST*AW-1:0] m_araddr,
   input  logic [N_MST-1:0]    m_arvalid,
   output logic [N_MST-1:0]    m_arready,
   output logic [DW-1:0]       m_rdata,
   output logic [1:0]          m_rresp,
   output logic [N_MST-1:0]    m_rvalid,
   input  logic [N_MST-1:0]    m_rready,
   output logic [AW-1:0]       s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DW-1:0]       s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready,
   output logic [N_MST-1:0]    o_grant
);

   localparam int unsigned GW = (N_MST > 1) ? $clog2(N_MST) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state_q;
   logic [1:0]    state_d;
   logic [AW-1:0] addr_q;
   logic [GW-1:0] gnt_q;
   logic [GW-1:0] win;
   logic [AW-1:0] win_addr;
   logic          take;

   // A grant is taken only in IDLE, with a request present and reset released
   assign take = (state_q == IDLE) && (|m_arvalid) && i_rst_n;

`ifdef ARB_FIXED_PRIO_EN
   // Fixed priority: lowest requesting index wins
   always_comb begin
      win = '0;
      for (int i = int'(N_MST) - 1; i >= 0; i--) begin
         if (m_arvalid[i]) win = GW'(i);
      end
   end
`else
   logic [GW-1:0] last_gnt;
   logic [GW-1:0] cand;
   logic          found;

   // Round-robin: search from last_gnt+1 and wrap, first requester wins
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 1; i <= int'(N_MST); i++) begin
         cand = GW'((int'(last_gnt) + i) % int'(N_MST));
         if (!found && m_arvalid[cand]) begin
            win   = cand;
            found = 1'b1;
         end
      end
   end

   // Remember the last winner; reset value gives master 0 first priority
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)  last_gnt <= GW'(N_MST - 1);
      else if (take) last_gnt <= win;
   end
`endif

   // Select the winning master's address slice
   always_comb begin
      win_addr = '0;
      for (int k = 0; k < int'(N_MST); k++) begin
         if (win == GW'(k)) win_addr = m_araddr[k*AW +: AW];
      end
   end

   // Latch address and owner of the transaction at grant time
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         addr_q <= '0;
         gnt_q  <= '0;
      end else if (take) begin
         addr_q <= win_addr;
         gnt_q  <= win;
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and channel routing; response path is pass-through in RESP
   always_comb begin
      state_d   = state_q;
      m_arready = '0;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_rready  = 1'b0;
      m_rvalid  = '0;
      m_rdata   = '0;
      m_rresp   = '0;
      o_grant   = '0;
      case (state_q)
         IDLE: begin
            if (take) begin
               m_arready[win] = 1'b1;
               state_d        = ADDR;
            end
         end
         ADDR: begin
            s_arvalid      = 1'b1;
            s_araddr       = addr_q;
            o_grant[gnt_q] = 1'b1;
            if (s_arready) state_d = RESP;
         end
         RESP: begin
            o_grant[gnt_q]  = 1'b1;
            s_rready        = m_rready[gnt_q];
            m_rvalid[gnt_q] = s_rvalid;
            m_rdata         = s_rdata;
            m_rresp         = s_rresp;
            if (s_rvalid && m_rready[gnt_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
